// File: rtl/traffic_light_pkg.sv
// Shared lamp codes, approach directions and FSM state encodings for traffic_light1.
package traffic_light_pkg;

    localparam logic [1:0] LIGHT_RED    = 2'b00;
    localparam logic [1:0] LIGHT_YELLOW = 2'b01;
    localparam logic [1:0] LIGHT_GREEN  = 2'b10;

    localparam logic [1:0] DIR_N = 2'd0;
    localparam logic [1:0] DIR_W = 2'd1;
    localparam logic [1:0] DIR_S = 2'd2;
    localparam logic [1:0] DIR_E = 2'd3;

    // Bits [2:1] carry the served direction, bit 0 selects yellow, bit 3 marks ALL_RED.
    typedef logic [3:0] state_t;

    localparam state_t ST_N_GREEN  = 4'd0;
    localparam state_t ST_N_YELLOW = 4'd1;
    localparam state_t ST_W_GREEN  = 4'd2;
    localparam state_t ST_W_YELLOW = 4'd3;
    localparam state_t ST_S_GREEN  = 4'd4;
    localparam state_t ST_S_YELLOW = 4'd5;
    localparam state_t ST_E_GREEN  = 4'd6;
    localparam state_t ST_E_YELLOW = 4'd7;
    localparam state_t ST_ALL_RED  = 4'd8;

    function automatic state_t green_state(input logic [1:0] dir);
        return {1'b0, dir, 1'b0};
    endfunction

endpackage

// File: rtl/traffic_light1_phase_timer.sv
// Dwell counter for one FSM phase: o_done is high while the count equals i_dwell-1.
// i_clear restarts the count at 0 on the next clock; async active-low reset.
module phase_timer (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_clear,
    input  logic [7:0] i_dwell,
    output logic       o_done
);

    logic [7:0] r_cnt;

    assign o_done = (r_cnt == (i_dwell - 8'd1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= 8'd0;
        end else if (i_clear) begin
            r_cnt <= 8'd0;
        end else begin
            r_cnt <= r_cnt + 8'd1;
        end
    end

endmodule

// File: rtl/traffic_light1.sv
// Fixed-time round-robin four-way signal controller (N -> W -> S -> E), Moore outputs.
// Define ALL_RED_EN to insert an all-red clearance phase after every yellow.
module traffic_light1
    import traffic_light_pkg::*;
#(
    parameter int unsigned GREEN_CYCLES   = 8,
    parameter int unsigned YELLOW_CYCLES  = 3
`ifdef ALL_RED_EN
    ,
    parameter int unsigned ALL_RED_CYCLES = 2
`endif
) (
    input  logic       clk,
    input  logic       rst,
    output logic [1:0] north_light,
    output logic [1:0] west_light,
    output logic [1:0] south_light,
    output logic [1:0] east_light
);

    localparam logic [7:0] L_GREEN  = 8'(GREEN_CYCLES);
    localparam logic [7:0] L_YELLOW = 8'(YELLOW_CYCLES);
`ifdef ALL_RED_EN
    localparam logic [7:0] L_ALLRED = 8'(ALL_RED_CYCLES);
`endif

    state_t     r_state;
    state_t     w_next;
    logic       w_done;
    logic       w_clear;
    logic [7:0] w_dwell;
    logic [1:0] w_dir;
    logic [1:0] w_dir_next;

    assign w_dir      = r_state[2:1];
    assign w_dir_next = 2'(w_dir + 2'd1);
    assign w_clear    = (w_next != r_state);

    always_comb begin
        w_dwell = r_state[0] ? L_YELLOW : L_GREEN;
`ifdef ALL_RED_EN
        if (r_state == ST_ALL_RED) begin
            w_dwell = L_ALLRED;
        end
`endif
    end

    phase_timer u_timer (
        .clk     (clk),
        .rst     (rst),
        .i_clear (w_clear),
        .i_dwell (w_dwell),
        .o_done  (w_done)
    );

`ifdef ALL_RED_EN
    logic [1:0] r_next_dir;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_next_dir <= DIR_W;
        end else if (!r_state[3] && r_state[0] && w_done) begin
            r_next_dir <= w_dir_next;
        end
    end
`endif

    // Any encoding outside the listed states (e.g. an upset) recovers to N_GREEN.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_N_GREEN, ST_W_GREEN, ST_S_GREEN, ST_E_GREEN: begin
                if (w_done) w_next = r_state | 4'd1;
            end
            ST_N_YELLOW, ST_W_YELLOW, ST_S_YELLOW, ST_E_YELLOW: begin
`ifdef ALL_RED_EN
                if (w_done) w_next = ST_ALL_RED;
`else
                if (w_done) w_next = green_state(w_dir_next);
`endif
            end
`ifdef ALL_RED_EN
            ST_ALL_RED: begin
                if (w_done) w_next = green_state(r_next_dir);
            end
`endif
            default: w_next = ST_N_GREEN;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_N_GREEN;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        north_light = LIGHT_RED;
        west_light  = LIGHT_RED;
        south_light = LIGHT_RED;
        east_light  = LIGHT_RED;
        if (!r_state[3]) begin
            case (w_dir)
                DIR_N:   north_light = r_state[0] ? LIGHT_YELLOW : LIGHT_GREEN;
                DIR_W:   west_light  = r_state[0] ? LIGHT_YELLOW : LIGHT_GREEN;
                DIR_S:   south_light = r_state[0] ? LIGHT_YELLOW : LIGHT_GREEN;
                default: east_light  = r_state[0] ? LIGHT_YELLOW : LIGHT_GREEN;
            endcase
        end
    end

endmodule

// File: tb/tb_traffic_light1.sv
// Scoreboard bench: default-timing controller plus a 1/1-dwell corner instance under random resets.
module tb_traffic_light1;

    localparam int G  = 8;
    localparam int Y  = 3;
`ifdef ALL_RED_EN
    localparam int R  = 2;
    localparam int R2 = 2;
`else
    localparam int R  = 0;
    localparam int R2 = 0;
`endif
    localparam int P = 4 * (G + Y + R);

    logic clk;
    logic rst;
    logic [1:0] n1, w1, s1, e1;
    logic [1:0] n2, w2, s2, e2;

    traffic_light1 #(.GREEN_CYCLES(G), .YELLOW_CYCLES(Y)) u_dut (
        .clk(clk), .rst(rst),
        .north_light(n1), .west_light(w1), .south_light(s1), .east_light(e1)
    );

    traffic_light1 #(.GREEN_CYCLES(1), .YELLOW_CYCLES(1)) u_corner (
        .clk(clk), .rst(rst),
        .north_light(n2), .west_light(w2), .south_light(s2), .east_light(e2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] exp1;
        logic [7:0] exp2;
        bit         cont;
    } item_t;

    item_t sb[$];
    int    n_cmp = 0;
    int    n_bad = 0;
    int    k     = 0;

    // Lamps {N,W,S,E} after k rising edges out of reset, from the schedule itself.
    function automatic logic [7:0] model(input int kk, input int g, input int y, input int r);
        int ph;
        int p;
        int d;
        int w;
        logic [1:0] c;
        logic [7:0] v;
        ph = g + y + r;
        p  = kk % (4 * ph);
        d  = p / ph;
        w  = p % ph;
        if (w < g)          c = 2'b10;
        else if (w < g + y) c = 2'b01;
        else                c = 2'b00;
        v = 8'h00;
        v[(7 - 2 * d) -: 2] = c;
        return v;
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic invariants(input string tag, input logic [7:0] cur, input logic [7:0] prev, input bit cont);
        int active;
        logic [1:0] c;
        logic [1:0] p;
        active = 0;
        for (int i = 0; i < 4; i++) begin
            c = cur[2*i +: 2];
            p = prev[2*i +: 2];
            if (c != 2'b00) active++;
            chk({tag, "_no_code11"}, {6'd0, c == 2'b11}, 8'd0);
            if (cont && p == 2'b10 && c != 2'b10)
                chk({tag, "_green_then_yellow"}, {6'd0, c}, 8'h01);
        end
        chk({tag, "_one_active"}, {7'd0, active <= 1}, 8'd1);
    endtask

    logic [7:0] prev1 = 8'h00;
    logic [7:0] prev2 = 8'h00;
    logic [7:0] act1;
    logic [7:0] act2;
    item_t      it;

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            it   = sb.pop_front();
            act1 = {n1, w1, s1, e1};
            act2 = {n2, w2, s2, e2};
            chk("dut_lamps", act1, it.exp1);
            chk("corner_lamps", act2, it.exp2);
            invariants("dut", act1, prev1, it.cont);
            invariants("corner", act2, prev2, it.cont);
            prev1 = act1;
            prev2 = act2;
        end
    end

    task automatic cycle();
        item_t x;
        @(posedge clk);
        if (rst) k++;
        else     k = 0;
        #1;
        x.exp1 = model(k, G, Y, R);
        x.exp2 = model(k, 1, 1, R2);
        x.cont = rst;
        sb.push_back(x);
    endtask

    // Asynchronous assertion mid-cycle: lamps must snap to reset values before any edge.
    task automatic reset_pulse(input int hold, input int ofs);
        @(negedge clk);
        #(ofs);
        rst = 1'b0;
        #1;
        chk("async_reset_dut", {n1, w1, s1, e1}, 8'b10_00_00_00);
        chk("async_reset_corner", {n2, w2, s2, e2}, 8'b10_00_00_00);
        repeat (hold) cycle();
        @(negedge clk);
        #1 rst = 1'b1;
    endtask

    initial begin
        int guard;
        rst = 1'b0;
        #1;
        chk("reset_dut_t0", {n1, w1, s1, e1}, 8'b10_00_00_00);
        chk("reset_corner_t0", {n2, w2, s2, e2}, 8'b10_00_00_00);
        repeat (2) cycle();
        @(negedge clk);
        #1 rst = 1'b1;
        repeat (200) cycle();

        guard = 0;
        while ((k % P) != (G + Y + R + G + 1) && guard < 2 * P) begin
            cycle();
            guard++;
        end
        chk("reach_w_yellow", {n1, w1, s1, e1}, 8'b00_01_00_00);
        reset_pulse(1, 2);

        repeat (30) cycle();
        reset_pulse(1, 3);
        repeat (60) cycle();

        for (int ep = 0; ep < 6; ep++) begin
            repeat ($urandom_range(20, 150)) cycle();
            reset_pulse($urandom_range(1, 3), $urandom_range(1, 4));
        end
        repeat (P + 5) cycle();

        for (int i = 0; i < 5 && sb.size() > 0; i++) @(negedge clk);
        chk("scoreboard_drained", 8'(sb.size()), 8'd0);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
